shape_sequencer: RTL and testbench
==================================

SHAPE_SEQUENCER -- requirements
Module: shape_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  draw command offered; cmd_ready  out  1  FIFO can accept.
REQ-005 cmd_colour  in  3 / cmd_cx  in  8 / cmd_cy  in  7 / cmd_diam  in  8  command fields.
REQ-006 eng_start  out  1  level start to reuleaux engine; eng_done  in  1  engine completion level.
REQ-007 eng_colour  out  3 / eng_cx  out  8 / eng_cy  out  7 / eng_diam  out  8  registered job fields to engine.
REQ-008 eng_vga_x  in  8 / eng_vga_y  in  7 / eng_vga_colour  in  3 / eng_vga_plot  in  1  engine pixel stream.
REQ-009 vga_x  out  8 / vga_y  out  7 / vga_colour  out  3 / vga_plot  out  1  registered pixel stream to framebuffer.
REQ-010 busy  out  1  high when state not IDLE or FIFO non-empty; all_done  out  1  = !busy.
REQ-011 pix_count  out  16  plotted-pixel counter (present only with SHAPE_SEQ_PIXCNT_EN).

Function
REQ-012 Push when cmd_valid && cmd_ready; cmd_ready = (count < DEPTH); push into full FIFO is impossible.
REQ-013 Simultaneous push and pop: count unchanged, both occur; FIFO pointers wrap modulo DEPTH.
REQ-014 FSM states IDLE, LOAD, RUN, RELEASE.
REQ-015 IDLE: FIFO non-empty -> LOAD; else stay.
REQ-016 LOAD: pop head into eng_* field registers, -> RUN (one cycle).
REQ-017 RUN: eng_start = 1 (decoded from state register, glitch-free); eng_done = 1 -> RELEASE.
REQ-018 RELEASE: eng_start = 0; remain until eng_done = 0, then -> LOAD if FIFO non-empty else IDLE.
REQ-019 Latency: command accepted at edge T into empty, idle sequencer -> eng_start high from edge T+2.
REQ-020 eng_* fields are stable throughout RUN and RELEASE; new pushes never alter them.
REQ-021 Pixel forward: at each edge vga_plot <= eng_vga_plot && state==RUN && eng_vga_x<160 && eng_vga_y<120; x/y/colour registered same edge (1-cycle latency).
REQ-022 Pixels from engine in IDLE, LOAD or RELEASE are dropped (vga_plot 0).
REQ-023 eng_done already high on RUN entry: transition to RELEASE next edge, no hang.

Reset
REQ-024 rst_n low at any time, including mid-RUN: state IDLE, FIFO empty, eng_start 0, eng_* 0, vga_* 0, vga_plot 0, pix_count 0.
REQ-025 After reset cmd_ready = 1, busy = 0, all_done = 1; in-flight job abandoned, not replayed.

Configuration
REQ-026 Macro SHAPE_SEQ_PIXCNT_EN defined: pix_count increments on every cycle vga_plot is registered high, saturates at 65535, clears when LOAD pops a job.
REQ-027 Macro undefined: pix_count port and counter logic absent; all other behaviour identical.

Verification
REQ-028 Push one job (cx 80, cy 60, diam 40, colour 2) at edge T -> eng_start high at T+2, fields match, vga_plot only during RUN.
REQ-029 Push 5 jobs back-to-back with DEPTH 4 and engine stalled -> cmd_ready low after 4th (5th also held if first popped); all 5 run in order.
REQ-030 Engine drops done 3 cycles after start falls -> sequencer stays RELEASE 3 cycles, then LOAD next job; start low >= 1 cycle between jobs.
REQ-031 Engine emits x=165 or y=125 with plot=1 in RUN -> vga_plot 0; x=159,y=119 -> vga_plot 1 next cycle.
REQ-032 Assert rst_n low mid-RUN with 2 jobs queued -> all outputs per REQ-024 asynchronously; after release, no engine start until new push.
REQ-033 With SHAPE_SEQ_PIXCNT_EN, job plotting 100 valid pixels -> pix_count 100 at done, 0 after next LOAD.

Source files
------------

// File: rtl/shape_sequencer_if.sv
// shape_sequencer_if
// Bundles the command handshake, the engine job/done handshake and both
// pixel streams used by shape_sequencer.
//   master : the side that issues commands, implements the drawing engine
//            and consumes the framebuffer pixel stream
//   slave  : the sequencer itself
interface shape_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_colour;
    logic [7:0] cmd_cx;
    logic [6:0] cmd_cy;
    logic [7:0] cmd_diam;

    logic       eng_start;
    logic       eng_done;
    logic [2:0] eng_colour;
    logic [7:0] eng_cx;
    logic [6:0] eng_cy;
    logic [7:0] eng_diam;

    logic [7:0] eng_vga_x;
    logic [6:0] eng_vga_y;
    logic [2:0] eng_vga_colour;
    logic       eng_vga_plot;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output cmd_valid, cmd_colour, cmd_cx, cmd_cy, cmd_diam,
        input  cmd_ready,
        input  eng_start, eng_colour, eng_cx, eng_cy, eng_diam,
        output eng_done,
        output eng_vga_x, eng_vga_y, eng_vga_colour, eng_vga_plot,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  cmd_valid, cmd_colour, cmd_cx, cmd_cy, cmd_diam,
        output cmd_ready,
        output eng_start, eng_colour, eng_cx, eng_cy, eng_diam,
        input  eng_done,
        input  eng_vga_x, eng_vga_y, eng_vga_colour, eng_vga_plot,
        output vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/shape_sequencer.sv
// shape_sequencer
// Queues draw commands in a DEPTH-entry FIFO and hands them one at a time
// to a shape engine, forwarding the engine's pixels (clipped to 160x120)
// to the framebuffer while a job is running.
//
// Ports
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   bus       shape_sequencer_if.slave: command handshake, engine job
//             fields/start/done, engine pixel stream in, pixel stream out
//   busy      state not IDLE or FIFO non-empty
//   all_done  !busy
//   pix_count plotted-pixel counter (only with SHAPE_SEQ_PIXCNT_EN defined)
//
// Optional feature macro: SHAPE_SEQ_PIXCNT_EN
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | nothing running, waiting for the FIFO to become non-empty
// LOAD    | pop FIFO head into the engine field registers (one cycle)
// RUN     | eng_start high, waiting for eng_done
// RELEASE | eng_start low, waiting for eng_done to drop
module shape_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shape_sequencer_if.slave      bus,
    output logic                  busy,
`ifdef SHAPE_SEQ_PIXCNT_EN
    output logic                  all_done,
    output logic [15:0]           pix_count
`else
    output logic                  all_done
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // {colour, cx, cy, diam}
    logic [25:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, fifo_empty;

    logic       eng_start_q;
    logic [2:0] eng_colour_q;
    logic [7:0] eng_cx_q;
    logic [6:0] eng_cy_q;
    logic [7:0] eng_diam_q;

    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic [2:0] vga_colour_q;
    logic       vga_plot_q;
    logic       plot_nxt;

    assign fifo_empty    = (count == '0);
    assign bus.cmd_ready = (count < DEPTH_C);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // Only LOAD pops, and LOAD is entered only with a non-empty FIFO.
    assign pop           = (state == S_LOAD);

    // Storage needs no reset: emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_colour, bus.cmd_cx, bus.cmd_cy, bus.cmd_diam};
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (!fifo_empty) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_RUN;
            S_RUN:     if (bus.eng_done) state_nxt = S_RELEASE;
            S_RELEASE: if (!bus.eng_done) state_nxt = fifo_empty ? S_IDLE : S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // eng_start is a flop that mirrors "state == RUN" exactly, so the engine
    // never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_start_q  <= 1'b0;
            eng_colour_q <= '0;
            eng_cx_q     <= '0;
            eng_cy_q     <= '0;
            eng_diam_q   <= '0;
        end else begin
            eng_start_q <= (state_nxt == S_RUN);
            if (pop) begin
                {eng_colour_q, eng_cx_q, eng_cy_q, eng_diam_q} <= mem[rd_ptr];
            end
        end
    end

    assign plot_nxt = bus.eng_vga_plot && (state == S_RUN) &&
                      (bus.eng_vga_x < 8'd160) && (bus.eng_vga_y < 7'd120);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            vga_x_q      <= bus.eng_vga_x;
            vga_y_q      <= bus.eng_vga_y;
            vga_colour_q <= bus.eng_vga_colour;
            vga_plot_q   <= plot_nxt;
        end
    end

`ifdef SHAPE_SEQ_PIXCNT_EN
    // Counts alongside vga_plot being loaded high; cleared by each new job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count <= '0;
        end else if (pop) begin
            pix_count <= '0;
        end else if (plot_nxt && (pix_count != 16'hFFFF)) begin
            pix_count <= pix_count + 16'd1;
        end
    end
`endif

    assign bus.eng_start  = eng_start_q;
    assign bus.eng_colour = eng_colour_q;
    assign bus.eng_cx     = eng_cx_q;
    assign bus.eng_cy     = eng_cy_q;
    assign bus.eng_diam   = eng_diam_q;

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;

    assign busy     = (state != S_IDLE) || !fifo_empty;
    assign all_done = !busy;

endmodule

// File: tb/tb_shape_sequencer.sv
// tb_shape_sequencer
// Directed bench for shape_sequencer (DEPTH 4). Accepted commands are pushed
// to a scoreboard queue and popped when the engine sees eng_start rise.
module tb_shape_sequencer;

    typedef struct packed {
        logic [2:0] colour;
        logic [7:0] cx;
        logic [6:0] cy;
        logic [7:0] diam;
    } job_t;

    logic clk;
    logic rst_n;
    logic busy;
    logic all_done;
`ifdef SHAPE_SEQ_PIXCNT_EN
    logic [15:0] pix_count;
`endif

    int checks   = 0;
    int failures = 0;
    job_t sb[$];

    shape_sequencer_if bus ();

    shape_sequencer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
`ifdef SHAPE_SEQ_PIXCNT_EN
        .all_done (all_done),
        .pix_count(pix_count)
`else
        .all_done (all_done)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic plot, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c);
        bus.eng_vga_plot   = plot;
        bus.eng_vga_x      = x;
        bus.eng_vga_y      = y;
        bus.eng_vga_colour = c;
    endtask

    // Offers j until accepted; returns #1 after the accepting edge.
    task automatic push_job(input job_t j);
        logic accepted;
        accepted       = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_colour = j.colour;
        bus.cmd_cx     = j.cx;
        bus.cmd_cy     = j.cy;
        bus.cmd_diam   = j.diam;
        for (int i = 0; i < 40 && !accepted; i++) begin
            if (bus.cmd_ready) begin
                tick();
                sb.push_back(j);
                accepted = 1'b1;
            end else begin
                tick();
            end
        end
        bus.cmd_valid = 1'b0;
        check("push_accept", 32'(accepted), 32'd1);
    endtask

    task automatic check_fields(input string tag, input job_t e);
        check({tag, "_colour"}, 32'(bus.eng_colour), 32'(e.colour));
        check({tag, "_cx"},     32'(bus.eng_cx),     32'(e.cx));
        check({tag, "_cy"},     32'(bus.eng_cy),     32'(e.cy));
        check({tag, "_diam"},   32'(bus.eng_diam),   32'(e.diam));
    endtask

    // Engine model: wait for start, check job against scoreboard, plot npix
    // in-range pixels, raise done, hold it for `hold` cycles in RELEASE,
    // drop it and check the hand-off to the next job or to idle.
    task automatic serve_job(input int npix, input int pre_pix, input int hold);
        job_t e;
        for (int i = 0; i < 60 && !bus.eng_start; i++) tick();
        check("start_seen", 32'(bus.eng_start), 32'd1);
        if (sb.size() == 0) begin
            e = '0;
            check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
        end
        check_fields("job", e);
        for (int i = 0; i < npix; i++) begin
            set_pix(1'b1, 8'(i), 7'(i % 120), 3'(i));
            tick();
            check("pix_plot", 32'(bus.vga_plot), 32'd1);
            check("pix_x", 32'(bus.vga_x), 32'(i));
        end
        set_pix(1'b0, 8'd0, 7'd0, 3'd0);
        bus.eng_done = 1'b1;
        tick();
        check("start_fall", 32'(bus.eng_start), 32'd0);
`ifdef SHAPE_SEQ_PIXCNT_EN
        check("pix_count_done", 32'(pix_count), 32'(npix + pre_pix));
`endif
        for (int i = 0; i < hold; i++) begin
            set_pix(1'b1, 8'd5, 7'd5, 3'd1);
            tick();
            check("release_start", 32'(bus.eng_start), 32'd0);
            check("release_drop", 32'(bus.vga_plot), 32'd0);
            check("release_busy", 32'(busy), 32'd1);
            check_fields("release", e);
        end
        set_pix(1'b0, 8'd0, 7'd0, 3'd0);
        bus.eng_done = 1'b0;
        tick();
        check("post_release_start", 32'(bus.eng_start), 32'd0);
        if (sb.size() != 0) begin
            tick();
            check("next_start", 32'(bus.eng_start), 32'd1);
`ifdef SHAPE_SEQ_PIXCNT_EN
            check("pix_count_load", 32'(pix_count), 32'd0);
`endif
        end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_all_done", 32'(all_done), 32'd1);
        end
    endtask

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic       exp;
    } pix_vec_t;

    initial begin
        job_t ja, jb, jf;
        job_t five [5];
        pix_vec_t tbl [7];
        logic any_start;

        tbl[0] = '{1'b1, 8'd159, 7'd119, 1'b1};
        tbl[1] = '{1'b1, 8'd165, 7'd50,  1'b0};
        tbl[2] = '{1'b1, 8'd50,  7'd125, 1'b0};
        tbl[3] = '{1'b0, 8'd10,  7'd20,  1'b0};
        tbl[4] = '{1'b1, 8'd0,   7'd0,   1'b1};
        tbl[5] = '{1'b1, 8'd160, 7'd0,   1'b0};
        tbl[6] = '{1'b1, 8'd0,   7'd120, 1'b0};

        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_colour = '0;
        bus.cmd_cx     = '0;
        bus.cmd_cy     = '0;
        bus.cmd_diam   = '0;
        bus.eng_done   = 1'b0;
        set_pix(1'b0, 8'd0, 7'd0, 3'd0);

        // Reset values
        tick();
        tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_all_done", 32'(all_done), 32'd1);
        check("rst_eng_start", 32'(bus.eng_start), 32'd0);
        check("rst_vga_plot", 32'(bus.vga_plot), 32'd0);
        check("rst_eng_cx", 32'(bus.eng_cx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single job: latency T+2, pixel drop outside RUN, clipping boundary
        ja = '{3'd2, 8'd80, 7'd60, 8'd40};
        push_job(ja);
        check("lat_T0_start", 32'(bus.eng_start), 32'd0);
        check("lat_T0_busy", 32'(busy), 32'd1);
        set_pix(1'b1, 8'd10, 7'd10, 3'd3);
        tick();
        check("lat_T1_start", 32'(bus.eng_start), 32'd0);
        check("drop_idle", 32'(bus.vga_plot), 32'd0);
        tick();
        check("lat_T2_start", 32'(bus.eng_start), 32'd1);
        check("drop_load", 32'(bus.vga_plot), 32'd0);
        for (int i = 0; i < 7; i++) begin
            set_pix(tbl[i].plot, tbl[i].x, tbl[i].y, 3'(i));
            tick();
            check("clip_plot", 32'(bus.vga_plot), 32'(tbl[i].exp));
            if (tbl[i].exp) begin
                check("clip_x", 32'(bus.vga_x), 32'(tbl[i].x));
                check("clip_y", 32'(bus.vga_y), 32'(tbl[i].y));
                check("clip_colour", 32'(bus.vga_colour), 32'(i));
            end
        end
        serve_job(100, 2, 2);

        // Five jobs back-to-back, engine stalled; release holds 3 cycles
        for (int i = 0; i < 5; i++) begin
            five[i] = '{3'(i + 1), 8'(10 * i + 3), 7'(7 * i + 1), 8'(20 + i)};
            push_job(five[i]);
        end
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("full_sb_size", 32'(sb.size()), 32'd5);
        for (int i = 0; i < 5; i++) serve_job(3, 0, 3);

        // eng_done already high when RUN is entered
        bus.eng_done = 1'b1;
        jb = '{3'd5, 8'd120, 7'd100, 8'd9};
        push_job(jb);
        tick();
        tick();
        check("early_done_start", 32'(bus.eng_start), 32'd1);
        if (sb.size() != 0) jb = sb.pop_front();
        check_fields("early", jb);
        tick();
        check("early_done_fall", 32'(bus.eng_start), 32'd0);
        check("early_done_busy", 32'(busy), 32'd1);
        tick();
        check("early_done_hold", 32'(bus.eng_start), 32'd0);
        bus.eng_done = 1'b0;
        tick();
        check("early_done_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN with two jobs queued
        for (int i = 0; i < 3; i++) push_job(five[i]);
        for (int i = 0; i < 20 && !bus.eng_start; i++) tick();
        check("pre_rst_start", 32'(bus.eng_start), 32'd1);
        set_pix(1'b1, 8'd1, 7'd1, 3'd7);
        tick();
        check("pre_rst_plot", 32'(bus.vga_plot), 32'd1);
        set_pix(1'b0, 8'd0, 7'd0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_eng_start", 32'(bus.eng_start), 32'd0);
        check("arst_eng_cx", 32'(bus.eng_cx), 32'd0);
        check("arst_eng_diam", 32'(bus.eng_diam), 32'd0);
        check("arst_vga_plot", 32'(bus.vga_plot), 32'd0);
        check("arst_vga_x", 32'(bus.vga_x), 32'd0);
        check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_all_done", 32'(all_done), 32'd1);
`ifdef SHAPE_SEQ_PIXCNT_EN
        check("arst_pix_count", 32'(pix_count), 32'd0);
`endif
        sb.delete();
        #2;
        rst_n = 1'b1;
        any_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_start = any_start | bus.eng_start;
        end
        check("no_replay_start", 32'(any_start), 32'd0);
        check("no_replay_busy", 32'(busy), 32'd0);

        jf = '{3'd6, 8'd33, 7'd44, 8'd55};
        push_job(jf);
        serve_job(4, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
